// File: rtl/mapped_core_pkg.sv
// rtl/mapped_core_pkg.sv - shared types, default widths and helpers for mapped_core_scheduler
package mapped_core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    localparam int DEF_N_REQ         = 4;
    localparam int DEF_IN_W          = 14;
    localparam int DEF_OUT_W         = 8;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam logic [7:0] DEF_MISR_POLY = 8'hB8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr with explicit wrap
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    int             idx;
    logic [IDW-1:0] sel;
    logic           found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int i = 0; i < N; i++) begin
            // compare-and-subtract keeps non-power-of-2 N from aliasing
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IDW'(idx);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/mapped_core_scheduler.sv
// rtl/mapped_core_scheduler.sv - time-shares one mapped combinational core among requesters; CORE_MISR_EN adds misr_sig
module mapped_core_scheduler
    import mapped_core_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int IN_W          = DEF_IN_W,
    parameter int OUT_W         = DEF_OUT_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
`ifdef CORE_MISR_EN
    parameter logic [OUT_W-1:0] MISR_POLY = DEF_MISR_POLY,
`endif
    localparam int IDW = id_w(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*IN_W-1:0] req_data,
    output logic [IN_W-1:0]       core_in,
    input  logic [OUT_W-1:0]      core_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [OUT_W-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
`ifdef CORE_MISR_EN
    ,
    output logic [OUT_W-1:0]      misr_sig
`endif
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_t           state;
    state_t           state_d;
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             grant_fire;
    logic             capture;
    logic             release_fire;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d      = state;
        req_ready    = '0;
        grant_fire   = 1'b0;
        capture      = 1'b0;
        release_fire = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (|gnt)) begin
                    req_ready  = gnt;
                    grant_fire = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // rsp_valid is always high in RESP, so rsp_ready alone completes the handshake
                if (rsp_ready) begin
                    release_fire = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            core_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            cnt       <= '0;
        end else begin
            if (grant_fire) begin
                core_in <= req_data[gnt_idx*IN_W +: IN_W];
                rsp_id  <= gnt_idx;
                cnt     <= CW'(SETTLE_CYCLES - 1);
            end else if ((state == SETTLE) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_data  <= core_out;
                rsp_valid <= 1'b1;
            end
            if (release_fire) begin
                rsp_valid <= 1'b0;
                ptr       <= (rsp_id == IDW'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
            end
        end
    end

`ifdef CORE_MISR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_sig <= '0;
        end else if (capture) begin
            misr_sig <= {misr_sig[OUT_W-2:0], ^(misr_sig & MISR_POLY)} ^ core_out;
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mapped_core_scheduler.sv
// tb/tb_mapped_core_scheduler.sv - randomized model-checked bench for mapped_core_scheduler, plus a 3-requester wrap instance
module tb_mapped_core_scheduler;

    localparam int N    = 4;
    localparam int IN_W = 14;
    localparam int S    = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*IN_W-1:0] req_data;
    logic [IN_W-1:0] core_in;
    logic [7:0]      core_out;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_data;
    logic [1:0]      rsp_id;
    logic            busy;

    logic [2:0]      r3_valid;
    logic [2:0]      r3_ready;
    logic [3*IN_W-1:0] r3_data;
    logic [IN_W-1:0] r3_core_in;
    logic [7:0]      r3_core_out;
    logic            r3_rsp_valid;
    logic            r3_rsp_ready;
    logic [7:0]      r3_rsp_data;
    logic [1:0]      r3_rsp_id;
    logic            r3_busy;
`ifdef CORE_MISR_EN
    logic [7:0]      misr_sig;
    logic [7:0]      r3_misr_sig;
`endif

    assign core_out    = core_in[7:0] ^ core_in[13:6];
    assign r3_core_out = r3_core_in[7:0] ^ r3_core_in[13:6];

    mapped_core_scheduler #(.N_REQ(N), .IN_W(IN_W), .OUT_W(8), .SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .core_in(core_in), .core_out(core_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
`ifdef CORE_MISR_EN
        , .misr_sig(misr_sig)
`endif
    );

    mapped_core_scheduler #(.N_REQ(3), .IN_W(IN_W), .OUT_W(8), .SETTLE_CYCLES(S)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_ready(r3_ready), .req_data(r3_data),
        .core_in(r3_core_in), .core_out(r3_core_out), .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready),
        .rsp_data(r3_rsp_data), .rsp_id(r3_rsp_id), .busy(r3_busy)
`ifdef CORE_MISR_EN
        , .misr_sig(r3_misr_sig)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // job-level model: a job is pending from its accept edge until the response handshake
    int             cyc;
    int             m_ptr;
    int             m_id;
    int             m_acc;
    bit             m_pend;
    logic [7:0]     m_data;
    logic [7:0]     m_last;
    logic [IN_W-1:0] m_core_in;
    logic [7:0]     m_sig;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] core_fn(input logic [IN_W-1:0] v);
        return v[7:0] ^ v[13:6];
    endfunction

    function automatic logic [7:0] misr_next(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], ^(s & 8'hB8)} ^ d;
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[2'(j)]) return j;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[2'(k)]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        if (!rst_n || m_pend) return '0;
        g = pick();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic model_reset();
        cyc = 0; m_ptr = 0; m_id = 0; m_acc = 0; m_pend = 0;
        m_data = '0; m_last = '0; m_core_in = '0; m_sig = '0;
    endtask

    task automatic model_step();
        int g;
        cyc++;
        if (m_pend) begin
            if (cyc > m_acc + S && rsp_ready) begin
                m_pend = 0;
                m_ptr  = (m_id + 1) % N;
            end else if (cyc == m_acc + S) begin
                m_last = m_data;
                m_sig  = misr_next(m_sig, m_data);
            end
        end else begin
            g = pick();
            if (g >= 0) begin
                m_pend    = 1;
                m_id      = g;
                m_acc     = cyc;
                m_core_in = req_data[g*IN_W +: IN_W];
                m_data    = core_fn(m_core_in);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready()));
            chk("busy", 32'(busy), 32'(m_pend));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_pend && (cyc >= m_acc + S)));
            chk("rsp_data", 32'(rsp_data), 32'(m_last));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("core_in", 32'(core_in), 32'(m_core_in));
`ifdef CORE_MISR_EN
            chk("misr_sig", 32'(misr_sig), 32'(m_sig));
`endif
        end
    end

    initial begin
        int ids[$];
        int tms[$];
        int seq[$];
        int bad;
        bit found;
        logic [7:0] hold_d;
        logic [1:0] hold_id;

        clk = 0; rst_n = 0; req_valid = '0; req_data = '0; rsp_ready = 0;
        r3_valid = '0; r3_data = '0; r3_rsp_ready = 0;
        model_reset();
        chk_en = 1;
`ifdef CORE_MISR_EN
        chk("misr_model_pin", 32'(misr_next(misr_next(8'h00, 8'h01), 8'h02)), 32'h00);
`endif
        tick();
        tick();
        rst_n = 1;

        @(negedge clk); #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_core_in", 32'(core_in), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);

        req_data[13:0] = 14'h2A5C;
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        @(negedge clk); #1;
        chk("single_ready_once", 32'(req_ready), 32'h0);
        chk("single_valid_t1", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk); #1;
        chk("single_valid_t2", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk); #1;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_data", 32'(rsp_data), 32'hF5);
        chk("single_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (req_ready != '0) begin
                ids.push_back(oh_idx(req_ready));
                tms.push_back(cyc);
            end
            tick();
        end
        chk("rr_count", 32'(ids.size()), 32'd5);
        if (ids.size() == 5) begin
            chk("rr_order", {ids[0][7:0], ids[1][7:0], ids[2][7:0], ids[3][7:0]}, 32'h00010203);
            chk("rr_wrap", 32'(ids[4]), 32'd0);
            for (int i = 1; i < 5; i++) chk("rr_period", 32'(tms[i] - tms[i-1]), 32'd4);
        end

        rsp_ready = 0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) found = 1;
            else tick();
        end
        chk("bp_reach_valid", 32'(found), 32'd1);
        hold_d = rsp_data;
        hold_id = rsp_id;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk); #1;
            chk("bp_data", 32'(rsp_data), 32'(hold_d));
            chk("bp_id", 32'(rsp_id), 32'(hold_id));
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1;
        req_valid = '0;
        tick();
        @(negedge clk); #1;
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 0;

        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_settle_valid", 32'(rsp_valid), 32'd0);
        chk("rst_settle_busy", 32'(busy), 32'd0);
        chk("rst_settle_core_in", 32'(core_in), 32'd0);
        chk("rst_settle_data", 32'(rsp_data), 32'd0);
        chk("rst_settle_id", 32'(rsp_id), 32'd0);
        chk("rst_settle_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk); #1;
            chk("rst_no_stale", 32'(rsp_valid), 32'd0);
        end

        for (int i = 0; i < 2000; i++) begin
            req_valid = N'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) req_data[k*IN_W +: IN_W] = IN_W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 0;

        for (int k = 0; k < 3; k++) r3_data[k*IN_W +: IN_W] = IN_W'($urandom);
        r3_rsp_ready = 1;
        r3_valid = 3'b010;
        #1;
        chk("wrap_first_grant", 32'(r3_ready), 32'h2);
        tick();
        r3_valid = '0;
        for (int i = 0; i < 6; i++) tick();
        chk("wrap_idle", 32'(r3_busy), 32'd0);
        r3_valid = 3'b101;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (r3_ready != '0) begin
                seq.push_back(oh_idx({1'b0, r3_ready}));
                if (r3_ready[1]) bad++;
            end
            tick();
        end
        chk("wrap_grants", 32'(seq.size() >= 3), 32'd1);
        if (seq.size() >= 3) begin
            chk("wrap_order", {8'h0, seq[0][7:0], seq[1][7:0], seq[2][7:0]}, 32'h00020002);
        end
        chk("wrap_never_1", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
